// File: rtl/alu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_pkg : shared ALU control codes, ALUOp encodings and funct7 patterns
// Revision: 1.0
// ---------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SLTU = 4'b1000,
    ALU_SRA  = 4'b1001
  } alu_code_t;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10,
    ALUOP_ITYPE  = 2'b11
  } aluop_t;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Operation selected by funct3 when funct7 carries the base pattern.
  function automatic alu_code_t base_op(input logic [2:0] funct3);
    case (funct3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_decode : combinational ALUOp/funct7/funct3 to ALU control code decode
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_decode (
  input  logic [1:0] ALUOp,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output logic [3:0] code,
  output logic       illegal
);
  import alu_pkg::*;

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_MEM: code = ALU_ADD;
      ALUOP_BRANCH: begin
        case (funct3[2:1])
          2'b00:   code = ALU_SUB;
          2'b10:   code = ALU_SLT;
          2'b11:   code = ALU_SLTU;
          default: illegal = 1'b1;
        endcase
      end
      ALUOP_RTYPE: begin
        if (funct7 == F7_BASE)                         code = base_op(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) code = ALU_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) code = ALU_SRA;
        else                                           illegal = 1'b1;
      end
      default: begin
        // Immediate forms ignore funct7 except for the shift encodings.
        case (funct3)
          3'b001: begin
            if (funct7 == F7_BASE) code = ALU_SLL;
            else                   illegal = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     code = ALU_SRL;
            else if (funct7 == F7_ALT) code = ALU_SRA;
            else                       illegal = 1'b1;
          end
          default: code = base_op(funct3);
        endcase
      end
    endcase
    if (illegal) code = ALU_ADD;
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// alu_control_pipe : ALU control decode followed by an elastic valid/ready pipe
// Revision: 1.0
// ---------------------------------------------------------------------------
module alu_control_pipe #(
  parameter int STAGES = 2,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUOp,
  input  logic [6:0]        funct7,
  input  logic [2:0]        funct3,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] outALUControl,
  output logic              illegal,
  output logic [CNT_W-1:0]  illegal_count
);
  import alu_pkg::*;

  logic [3:0]        dec_code;
  logic              dec_ill;
  logic              rdy_q;
  logic              accept;
  logic [STAGES-1:0] valid_q, valid_d, move;
  logic [STAGES:0]   take, load;
  logic [CTRL_W-1:0] code_q   [STAGES];
  logic [CTRL_W-1:0] code_src [STAGES+1];
  logic              ill_q    [STAGES];
  logic              ill_src  [STAGES+1];
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  alu_decode u_decode (
    .ALUOp   (ALUOp),
    .funct7  (funct7),
    .funct3  (funct3),
    .code    (dec_code),
    .illegal (dec_ill)
  );

  // take[k]: slot k can receive this cycle; take[STAGES] is the consumer.
  always_comb begin
    logic [STAGES:0]   t;
    logic [STAGES-1:0] m;
    t         = '0;
    m         = '0;
    t[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      m[k] = valid_q[k] & t[k+1];
      t[k] = ~valid_q[k] | m[k];
    end
    take = t;
    move = m;
  end

  assign in_ready = rdy_q & take[0] & ~flush;
  assign accept   = in_valid & in_ready;
  assign load     = {move, accept};

  assign code_src[0] = CTRL_W'(dec_code);
  assign ill_src[0]  = dec_ill;

  always_comb begin
    valid_d = valid_q;
    for (int k = 0; k < STAGES; k++) begin
      if (flush)        valid_d[k] = 1'b0;
      else if (load[k]) valid_d[k] = 1'b1;
      else if (move[k]) valid_d[k] = 1'b0;
    end
  end

  assign cnt_d = (accept && dec_ill && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q   <= 1'b0;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      rdy_q   <= 1'b1;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign code_src[k+1] = code_q[k];
    assign ill_src[k+1]  = ill_q[k];

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        code_q[k] <= '0;
        ill_q[k]  <= 1'b0;
      end else if (load[k]) begin
        code_q[k] <= code_src[k];
        ill_q[k]  <= ill_src[k];
      end
    end
  end

  assign out_valid     = valid_q[STAGES-1];
  assign outALUControl = code_q[STAGES-1];
  assign illegal       = ill_q[STAGES-1];
  assign illegal_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_alu_control_pipe : directed stimulus, queue reference model, summary line
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_alu_control_pipe;
  localparam int STAGES = 2;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              in_valid, in_ready;
  logic [1:0]        ALUOp;
  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic              flush;
  logic              out_valid, out_ready;
  logic [CTRL_W-1:0] outALUControl;
  logic              illegal;
  logic [CNT_W-1:0]  illegal_count;

  int n_cmp = 0;
  int n_bad = 0;

  alu_control_pipe #(.STAGES(STAGES), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .ALUOp         (ALUOp),
    .funct7        (funct7),
    .funct3        (funct3),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .outALUControl (outALUControl),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  always #5 clock = ~clock;

  // R-type funct3 -> code table with funct7 = 0000000
  logic [3:0] BASE [8] = '{4'h2, 4'h4, 4'h7, 4'h8, 4'h3, 4'h5, 4'h1, 4'h0};

  function automatic logic [4:0] ref_dec(input logic [1:0] op, input logic [6:0] f7,
                                         input logic [2:0] f3);
    logic [3:0] c;
    logic       bad;
    c   = BASE[f3];
    bad = 1'b0;
    case (op)
      2'b00: c = 4'h2;
      2'b01: case (f3[2:1])
        2'b00:   c = 4'h6;
        2'b10:   c = 4'h7;
        2'b11:   c = 4'h8;
        default: bad = 1'b1;
      endcase
      2'b10: begin
        if (f7 == 7'h20 && f3 == 3'd0)      c = 4'h6;
        else if (f7 == 7'h20 && f3 == 3'd5) c = 4'h9;
        else if (f7 != 7'h00)               bad = 1'b1;
      end
      default: begin
        if (f3 == 3'd5 && f7 == 7'h20)                    c = 4'h9;
        else if ((f3 == 3'd1 || f3 == 3'd5) && f7 != 7'h00) bad = 1'b1;
      end
    endcase
    if (bad) c = 4'h2;
    return {bad, c};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic v, input logic [1:0] op, input logic [6:0] f7,
                        input logic [2:0] f3);
    in_valid = v;
    ALUOp    = op;
    funct7   = f7;
    funct3   = f3;
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Reference scoreboard: inputs are stable across each negedge, so what is
  // seen there is exactly what the following rising edge acts on.
  logic [4:0] q[$];
  logic [4:0] held;
  logic       stall_prev = 1'b0;
  logic       flush_prev = 1'b0;
  int         mcnt = 0;

  always @(negedge clock) begin
    if (!reset_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_code", outALUControl, 0);
      check("rst_illegal", illegal, 0);
      check("rst_count", illegal_count, 0);
      q.delete();
      mcnt       = 0;
      stall_prev = 1'b0;
      flush_prev = 1'b0;
    end else begin
      check("count", illegal_count, mcnt);
      if (stall_prev && !flush_prev) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", {illegal, outALUControl}, held);
      end
      if (out_valid) begin
        if (q.size() == 0) check("spurious_out", q.size(), 1);
        else begin
          check("result", {illegal, outALUControl}, q[0]);
          if (out_ready) void'(q.pop_front());
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {illegal, outALUControl};
      flush_prev = flush;
      if (flush) begin
        check("flush_ready", in_ready, 0);
        q.delete();
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_dec(ALUOp, funct7, funct3));
        if (ref_dec(ALUOp, funct7, funct3) >= 5'h10 && mcnt != 255) mcnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [1:0] v_op [3];
  logic [6:0] v_f7 [3];
  logic [2:0] v_f3 [3];
  logic [3:0] got  [8];
  int         cyc  [8];
  int         n, idx;

  initial begin
    reset_n   = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    set_in(0, 2'd0, 7'h00, 3'd0);
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b1;
    #1 check("ready_before_edge", in_ready, 0);
    tick;
    check("ready_after_edge", in_ready, 1);
    check("idle_valid", out_valid, 0);

    // R-type SRA: result two cycles after acceptance
    set_in(1, 2'b10, 7'h20, 3'd5);
    tick;
    set_in(0, 2'd0, 7'h00, 3'd0);
    check("sra_cycle1_valid", out_valid, 0);
    tick;
    check("sra_cycle2_valid", out_valid, 1);
    check("sra_code", outALUControl, 4'b1001);
    check("sra_illegal", illegal, 0);
    tick;

    // Back-to-back ADD, SUB, AND, OR
    n = 0;
    for (int i = 0; i < 6; i++) begin
      case (i)
        0:       set_in(1, 2'b10, 7'h00, 3'd0);
        1:       set_in(1, 2'b10, 7'h20, 3'd0);
        2:       set_in(1, 2'b10, 7'h00, 3'd7);
        3:       set_in(1, 2'b10, 7'h00, 3'd6);
        default: set_in(0, 2'd0, 7'h00, 3'd0);
      endcase
      tick;
      if (out_valid && n < 8) begin
        got[n] = outALUControl;
        cyc[n] = i;
        n++;
      end
    end
    check("b2b_count", n, 4);
    check("b2b_0", got[0], 4'b0010);
    check("b2b_1", got[1], 4'b0110);
    check("b2b_2", got[2], 4'b0000);
    check("b2b_3", got[3], 4'b0001);
    check("b2b_first_cycle", cyc[0], 1);
    check("b2b_last_cycle", cyc[3], 4);

    // Stall with three requests: XOR, SLL, I-type SRA
    v_op = '{2'b10, 2'b10, 2'b11};
    v_f7 = '{7'h00, 7'h00, 7'h20};
    v_f3 = '{3'd4, 3'd1, 3'd5};
    out_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      if (idx < 3) set_in(1, v_op[idx], v_f7[idx], v_f3[idx]);
      #1;
      if (in_ready) idx++;
      tick;
    end
    check("stall_accepts", idx, STAGES);
    check("stall_in_ready", in_ready, 0);
    check("stall_front_code", outALUControl, 4'b0011);
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (idx < 3) set_in(1, v_op[idx], v_f7[idx], v_f3[idx]);
      else         set_in(0, 2'd0, 7'h00, 3'd0);
      #1;
      if (out_valid && n < 8) begin
        got[n] = outALUControl;
        n++;
      end
      if (in_valid && in_ready) idx++;
      tick;
    end
    check("drain_count", n, 3);
    check("drain_0", got[0], 4'b0011);
    check("drain_1", got[1], 4'b0100);
    check("drain_2", got[2], 4'b1001);

    // Illegal funct7 300 times: counter saturates
    for (int i = 0; i < 300; i++) begin
      set_in(1, 2'b10, 7'h01, 3'd0);
      tick;
      if (i == 99) check("count_100", illegal_count, 100);
    end
    check("illegal_flag", illegal, 1);
    check("illegal_code", outALUControl, 4'b0010);
    check("count_sat", illegal_count, 255);
    set_in(0, 2'd0, 7'h00, 3'd0);
    repeat (3) tick;

    // Flush with two entries in flight
    out_ready = 1'b0;
    set_in(1, 2'b01, 7'h00, 3'd0);
    tick;
    set_in(1, 2'b01, 7'h00, 3'd4);
    tick;
    set_in(1, 2'b01, 7'h00, 3'd6);
    flush = 1'b1;
    #1 check("flush_in_ready", in_ready, 0);
    tick;
    flush = 1'b0;
    set_in(0, 2'd0, 7'h00, 3'd0);
    check("flush_out_valid", out_valid, 0);
    tick;
    check("flush_out_valid2", out_valid, 0);
    out_ready = 1'b1;

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2'b01, 7'h00, 3'd2);
      tick;
    end
    set_in(1, 2'b11, 7'h00, 3'd3);
    #2 reset_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_code", outALUControl, 0);
    check("arst_illegal", illegal, 0);
    check("arst_count", illegal_count, 0);
    check("arst_in_ready", in_ready, 0);
    @(posedge clock);
    #3 reset_n = 1'b1;
    #1 check("arst_ready_pre_edge", in_ready, 0);
    tick;
    check("arst_ready_post_edge", in_ready, 1);
    tick;
    set_in(0, 2'd0, 7'h00, 3'd0);
    repeat (4) tick;
    check("final_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
